// File: rtl/floor_call_if.sv
// Button, car-status and call/target signals between the elevator FSM side and the call register.
interface floor_call_if;
  logic       button1_n;
  logic       button2_n;
  logic       button3_n;
  logic [1:0] current_floor;
  logic       door_open;
  logic       moving;
  logic       sos_mode;
  logic       led1;
  logic       led2;
  logic       led3;
  logic [1:0] target_floor;
  logic       target_valid;
  logic       dir_up;

  modport master (
    output button1_n, button2_n, button3_n,
    output current_floor, door_open, moving, sos_mode,
    input  led1, led2, led3,
    input  target_floor, target_valid, dir_up
  );

  modport slave (
    input  button1_n, button2_n, button3_n,
    input  current_floor, door_open, moving, sos_mode,
    output led1, led2, led3,
    output target_floor, target_valid, dir_up
  );
endinterface

// File: rtl/floor_call_register.sv
// Call-button conditioning, per-floor pending calls with LEDs, and next-target selection
// (direction-preserving, nearest-first) for the elevator car FSM.
module floor_call_register #(
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic         clk_50,
  input  logic         reset,
  floor_call_if.slave  bus
);

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_FLOORS:1] btn_raw;
  logic [NUM_FLOORS:1] sync_meta_q;
  logic [NUM_FLOORS:1] sync_q;
  logic [NUM_FLOORS:1] deb_q;
  logic [NUM_FLOORS:1] deb_prev_q;
  logic [CNT_W-1:0]    cnt_q [1:NUM_FLOORS];
  logic [NUM_FLOORS:1] press_c;
  logic [NUM_FLOORS:1] serve_c;
  logic [NUM_FLOORS:1] pending_q;
  logic [NUM_FLOORS:0] pend_ext;

  logic [1:0] target_floor_q;
  logic       target_valid_q;
  logic       dir_up_q;
  logic [1:0] target_floor_d;
  logic       target_valid_d;
  logic       dir_up_d;

  logic       eff_dir_c;
  logic       up_hit_c;
  logic       dn_hit_c;
  logic [1:0] up_floor_c;
  logic [1:0] dn_floor_c;
  logic [1:0] cf;

  assign btn_raw = {bus.button3_n, bus.button2_n, bus.button1_n};
  assign cf      = bus.current_floor;

  // Two-flop synchroniser followed by a stability counter per button
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync_meta_q <= '1;
      sync_q      <= '1;
      deb_q       <= '1;
      deb_prev_q  <= '1;
      for (int i = 1; i <= NUM_FLOORS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_meta_q <= btn_raw;
      sync_q      <= sync_meta_q;
      deb_prev_q  <= deb_q;
      for (int i = 1; i <= NUM_FLOORS; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the accepted release->press transition; releases are ignored
  assign press_c = deb_prev_q & ~deb_q;

  always_comb begin
    serve_c = '0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      serve_c[f] = (cf == 2'(f)) && bus.door_open && !bus.moving;
    end
  end

  // Serving a floor beats a simultaneous press on it; SOS wipes every call
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else if (bus.sos_mode) begin
      pending_q <= '0;
    end else begin
      for (int f = 1; f <= NUM_FLOORS; f++) begin
        if (serve_c[f]) begin
          pending_q[f] <= 1'b0;
        end else if (press_c[f]) begin
          pending_q[f] <= 1'b1;
        end
      end
    end
  end

  assign pend_ext = {pending_q, 1'b0};

  // Nearest pending floor above and below the car
  always_comb begin
    up_hit_c   = 1'b0;
    dn_hit_c   = 1'b0;
    up_floor_c = 2'd1;
    dn_floor_c = 2'd1;
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      if (pending_q[f] && (2'(f) > cf)) begin
        up_hit_c   = 1'b1;
        up_floor_c = 2'(f);
      end
    end
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (pending_q[f] && (2'(f) < cf)) begin
        dn_hit_c   = 1'b1;
        dn_floor_c = 2'(f);
      end
    end
  end

  // At a terminal floor a stopped car can only head back into the shaft
  always_comb begin
    eff_dir_c = dir_up_q;
    if (!bus.moving && (cf == 2'd3)) begin
      eff_dir_c = 1'b0;
    end else if (!bus.moving && (cf == 2'd1)) begin
      eff_dir_c = 1'b1;
    end
  end

  always_comb begin
    target_floor_d = target_floor_q;
    target_valid_d = target_valid_q;
    dir_up_d       = dir_up_q;
    if (bus.sos_mode || (pending_q == '0) || (cf == 2'd0)) begin
      target_valid_d = 1'b0;
    end else if (pend_ext[cf]) begin
      target_floor_d = cf;
      target_valid_d = 1'b1;
      dir_up_d       = eff_dir_c;
    end else if (eff_dir_c && up_hit_c) begin
      target_floor_d = up_floor_c;
      target_valid_d = 1'b1;
      dir_up_d       = 1'b1;
    end else if (!eff_dir_c && dn_hit_c) begin
      target_floor_d = dn_floor_c;
      target_valid_d = 1'b1;
      dir_up_d       = 1'b0;
    end else if (!bus.moving) begin
      // Only calls behind: reverse and take the nearest one
      target_floor_d = eff_dir_c ? dn_floor_c : up_floor_c;
      target_valid_d = 1'b1;
      dir_up_d       = !eff_dir_c;
    end else begin
      target_valid_d = 1'b0;
      dir_up_d       = eff_dir_c;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      target_floor_q <= 2'd1;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b1;
    end else begin
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
      dir_up_q       <= dir_up_d;
    end
  end

  assign bus.led1         = pending_q[1];
  assign bus.led2         = pending_q[2];
  assign bus.led3         = pending_q[3];
  assign bus.target_floor = target_floor_q;
  assign bus.target_valid = target_valid_q;
  assign bus.dir_up       = dir_up_q;

endmodule
